bus_arbiter: RTL
================

# bus_arbiter

Two-master arbiter sharing the single 32-bit memory bus between the Memory stage (data master, `dc_*`) and instruction fetch (fetch master, `ic_*`, read-only). Arbitration is combinational in an idle cycle, and the grant locks for multi-cycle transactions. The fixed data-first priority carries a starvation guard for fetch. Each master sees the standard `rd_req`/`wr_req`/`rw_wait` handshake as if it owned the bus alone.

## Interface
Parameters:
- `STARVE_MAX`, default 8: consecutive lost arbitrations after which fetch is promoted over data (range 1..15).

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `Nrst`, in, 1: reset. Synchronous, active-low.
- `dc_busaddr`, in, 32: data master word address.
- `dc_rd_req`, in, 1: data master read request.
- `dc_wr_req`, in, 1: data master write request.
- `dc_wr_data`, in, 32: data master write data.
- `dc_rd_data`, out, 32: read data returned to the data master.
- `dc_rw_wait`, out, 1: data master not complete this cycle.
- `ic_busaddr`, in, 32: fetch master address.
- `ic_rd_req`, in, 1: fetch master read request.
- `ic_rd_data`, out, 32: read data returned to fetch.
- `ic_rw_wait`, out, 1: fetch not complete this cycle.
- `bus_addr`, out, 32: downstream address.
- `bus_rd_req`, out, 1: downstream read request.
- `bus_wr_req`, out, 1: downstream write request.
- `bus_wr_data`, out, 32: downstream write data.
- `bus_rd_data`, in, 32: downstream read data.
- `bus_rw_wait`, in, 1: downstream not complete this cycle.

## Operation
- Registered state: `locked` (1b), `owner` (0 = dc, 1 = ic), `starve` (4b).
- Requests: dc requests when `dc_rd_req|dc_wr_req`. Both high together is illegal. ic requests when `ic_rd_req`.
- Selection when `locked=0`:
  - Only one master requesting: that master wins.
  - Both requesting: dc wins, unless `starve>=STARVE_MAX`, in which case ic wins.
- Selection when `locked=1`: `owner` wins unconditionally.
- The winner's address, requests and write data drive `bus_*`. With no winner, `bus_rd_req=bus_wr_req=0` and `bus_addr`/`bus_wr_data` are don't-care.
- `bus_rd_data` fans out unmodified to both `*_rd_data`. Data is valid only on the completing cycle.
- Completion of the winner: `bus_rw_wait=0` in a cycle where the winner is driving.
- A requesting master's `*_rw_wait` is 1 unless it is the winner and `bus_rw_wait=0`. A master not requesting sees `*_rw_wait=0`.
- Lock, at posedge:
  - Winner present and `bus_rw_wait=1`: `locked<=1`, `owner<=winner`.
  - Winner completes: `locked<=0`.
  - Locked owner drops its request: `locked<=0`. The transaction is abandoned, the bus is idle that cycle, and no completion is signalled.
- Starvation counter, at posedge:
  - ic requesting, not the winner, and `locked=0`: `starve` increments, saturating at 15.
  - ic completes: `starve<=0`.
  - ic not requesting: `starve<=0`.
- Reset: `Nrst=0` at posedge clears `locked`, `owner` and `starve` to 0.
  - While `Nrst=0`, `bus_rd_req=bus_wr_req=0`.
  - While `Nrst=0`, each `*_rw_wait` equals that master's request, so no completion is reported.
  - Reset mid-lock discards the transaction.

## Timing
- Zero added latency: with a zero-wait slave, a request issued on an idle bus completes in the same cycle.
- An N-wait-cycle slave gives N+1 cycles of `*_rw_wait`-inclusive occupancy. The grant is held for all of them.
- A loser's earliest grant is the cycle after the owner's completing cycle. There are no dead cycles between back-to-back transactions.
- Outputs are combinational from the inputs and the registered state. All state updates occur on the `clk` posedge.

## Configuration
- `BUS_ARBITER_RR_EN`
  - Defined: round-robin. On contention, the master that did not win the most recent completed transaction wins. A 1-bit `last` register is cleared to dc on reset. `starve` and `STARVE_MAX` are unused and the counter is not built.
  - Undefined: fixed dc priority with the starvation guard, as above.

## Test plan
- Idle bus, zero-wait slave, dc read of `32'h0000_1000` only -> same cycle: `bus_rd_req=1`, `bus_addr=32'h1000`, `dc_rw_wait=0`, `dc_rd_data=bus_rd_data`.
- Contention, slave waits 2 cycles: dc write plus ic read in cycle 0 -> dc owns cycles 0-2, `ic_rw_wait=1` throughout. ic granted in cycle 3 and completes there.
- Lock hold: ic wins via starvation while dc rises mid-transaction with `bus_rw_wait=1` -> bus stays on `ic_busaddr` until completion. dc is granted the following cycle.
- Starvation, macro undefined, `STARVE_MAX=8`: dc issues continuous zero-wait requests while ic is held high -> ic wins on the 9th cycle and `starve` returns to 0.
- Reset mid-lock: `Nrst=0` while dc is locked and `bus_rw_wait=1` -> `bus_rd_req=bus_wr_req=0` and `dc_rw_wait=1`. After release, dc re-arbitrates from the idle state.
- `BUS_ARBITER_RR_EN` defined: both masters request continuously with zero-wait -> grants alternate dc, ic, dc, ic starting with ic after reset.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master memory bus arbiter: data master (dc) has fixed priority, fetch (ic) has a starvation guard.
// Define BUS_ARBITER_RR_EN to replace fixed priority with round-robin contention resolution.
module bus_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic [31:0] dc_busaddr,
    input  logic        dc_rd_req,
    input  logic        dc_wr_req,
    input  logic [31:0] dc_wr_data,
    output logic [31:0] dc_rd_data,
    output logic        dc_rw_wait,
    input  logic [31:0] ic_busaddr,
    input  logic        ic_rd_req,
    output logic [31:0] ic_rd_data,
    output logic        ic_rw_wait,
    output logic [31:0] bus_addr,
    output logic        bus_rd_req,
    output logic        bus_wr_req,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rw_wait
);

    typedef enum logic {
        OWNER_DC = 1'b0,
        OWNER_IC = 1'b1
    } owner_t;

    logic   dc_req;
    logic   ic_req;
    logic   grant_dc;
    logic   grant_ic;
    logic   locked;
    owner_t owner;

`ifdef BUS_ARBITER_RR_EN
    owner_t last;
`else
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
    logic [3:0] starve;
`endif

    assign dc_req = dc_rd_req | dc_wr_req;
    assign ic_req = ic_rd_req;

    // A locked owner that drops its request leaves the bus idle rather than handing it over.
    always_comb begin
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if (Nrst) begin
            if (locked) begin
                grant_dc = (owner == OWNER_DC) && dc_req;
                grant_ic = (owner == OWNER_IC) && ic_req;
            end else if (dc_req && ic_req) begin
`ifdef BUS_ARBITER_RR_EN
                if (last == OWNER_DC) grant_ic = 1'b1;
                else                  grant_dc = 1'b1;
`else
                if (starve >= STARVE_LIMIT) grant_ic = 1'b1;
                else                        grant_dc = 1'b1;
`endif
            end else begin
                grant_dc = dc_req;
                grant_ic = ic_req;
            end
        end
    end

    assign bus_rd_req  = grant_dc ? dc_rd_req : (grant_ic & ic_rd_req);
    assign bus_wr_req  = grant_dc & dc_wr_req;
    assign bus_addr    = grant_ic ? ic_busaddr : dc_busaddr;
    assign bus_wr_data = dc_wr_data;

    assign dc_rd_data  = bus_rd_data;
    assign ic_rd_data  = bus_rd_data;
    assign dc_rw_wait  = dc_req & ~(grant_dc & ~bus_rw_wait);
    assign ic_rw_wait  = ic_req & ~(grant_ic & ~bus_rw_wait);

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            locked <= 1'b0;
            owner  <= OWNER_DC;
        end else if ((grant_dc || grant_ic) && bus_rw_wait) begin
            locked <= 1'b1;
            owner  <= grant_ic ? OWNER_IC : OWNER_DC;
        end else begin
            locked <= 1'b0;
        end
    end

`ifdef BUS_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (!Nrst) begin
            last <= OWNER_DC;
        end else if ((grant_dc || grant_ic) && !bus_rw_wait) begin
            last <= grant_ic ? OWNER_IC : OWNER_DC;
        end
    end
`else
    // Only unlocked losses count; waiting behind a locked dc transaction holds the count.
    always_ff @(posedge clk) begin
        if (!Nrst) begin
            starve <= 4'd0;
        end else if (!ic_req || (grant_ic && !bus_rw_wait)) begin
            starve <= 4'd0;
        end else if (!grant_ic && !locked && starve != 4'd15) begin
            starve <= starve + 4'd1;
        end
    end
`endif

endmodule
